timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_pkg.sv | 20 ++
 rtl/rr_arb.sv | 32 +++
 rtl/timer_sched.sv | 139 +++++++++++++
 tb/tb_timer_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding and width defaults for the timeout scheduler.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package timer_pkg;

   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Index width for a requester count; keeps one bit for the single-requester case.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin pick among requesters, starting at the slot after ptr.
// Latency: combinational.
// Backpressure: none; caller decides whether to act on the winner.
module rr_arb import timer_pkg::*; #(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic            vld
);

   // Scan ptr+1, ptr+2, ... with wrap; the first active requester wins.
   always_comb begin
      int idx;
      win = '0;
      vld = 1'b0;
      idx = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!vld && req[idx[IW-1:0]]) begin
            win[idx[IW-1:0]] = 1'b1;
            vld              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// Shares one prescaled down-counter among NREQ timeout requesters, round-robin.
// Latency: grant 1 cycle after request; done pulse load*(prescaler+1) enabled RUN cycles after LOAD.
// Backpressure: en=0 freezes arbitration and counting; dropping the owner's req aborts silently.
module timer_sched import timer_pkg::*; #(
   parameter  int NREQ = 4,
   parameter  int CW   = CW_DEF,
   localparam int IW   = idx_w(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CW-1:0]     prescaler,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*CW-1:0] load,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [IW-1:0]     cur_id,
   output logic [CW-1:0]     count
);

   state_t          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic [IW-1:0]   cur_id_q;
   logic [IW-1:0]   ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   ps_cnt_q;

   logic [NREQ-1:0] arb_win;
   logic            arb_vld;
   logic [IW-1:0]   arb_id_d;
   logic [CW-1:0]   load_arr [NREQ];
   logic [CW-1:0]   owner_load_d;
   logic            owner_req_d;

   rr_arb #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_arb (
      .req (req),
      .ptr (ptr_q),
      .win (arb_win),
      .vld (arb_vld)
   );

   // Unpack the flat load bus and select the owner's load and request.
   always_comb begin
      arb_id_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         load_arr[i] = load[i*CW +: CW];
         if (arb_win[i]) begin
            arb_id_d = IW'(i);
         end
      end
      owner_load_d = load_arr[cur_id_q];
      owner_req_d  = req[cur_id_q];
   end

   // Scheduler FSM with inline counter and prescaler; done is a registered one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         cur_id_q <= '0;
         ptr_q    <= IW'(NREQ - 1);
         count_q  <= '0;
         ps_cnt_q <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (en && arb_vld) begin
                  state_q  <= LOAD;
                  gnt_q    <= arb_win;
                  cur_id_q <= arb_id_d;
               end
            end
            LOAD: begin
               if (!owner_req_d) begin
                  // Abort: count keeps whatever it last held.
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  ptr_q   <= cur_id_q;
               end else begin
                  count_q  <= owner_load_d;
                  ps_cnt_q <= '0;
                  if (owner_load_d == '0) begin
                     state_q <= DONE;
                     gnt_q   <= '0;
                     done_q  <= gnt_q;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (!owner_req_d) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  ptr_q   <= cur_id_q;
               end else if (en) begin
                  // >= lets a prescaler lowered below ps_cnt fire on the very next cycle.
                  if (ps_cnt_q >= prescaler) begin
                     ps_cnt_q <= '0;
                     if (count_q != '0) begin
                        count_q <= count_q - CW'(1);
                     end
                     if (count_q <= CW'(1)) begin
                        state_q <= DONE;
                        gnt_q   <= '0;
                        done_q  <= gnt_q;
                     end
                  end else begin
                     ps_cnt_q <= ps_cnt_q + CW'(1);
                  end
               end
            end
            DONE: begin
               // Owner goes to the back of the round-robin order.
               state_q <= IDLE;
               ptr_q   <= cur_id_q;
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign busy   = (state_q != IDLE);
   assign cur_id = cur_id_q;
   assign count  = count_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: stimulus pushes expected grant/done events, a monitor pops them.
// Latency expectations are hand-computed per vector as absolute cycle numbers.
// Inline checks cover reset values, count steps, aborts and stalls.
module tb_timer_sched;

   localparam int NREQ = 4;
   localparam int CW   = 16;

   logic              clk;
   logic              rst;
   logic              en;
   logic [CW-1:0]     prescaler;
   logic [NREQ-1:0]   req;
   logic [NREQ*CW-1:0] load;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [1:0]        cur_id;
   logic [CW-1:0]     count;

   typedef struct {
      bit is_done;
      int id;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;

   timer_sched #(
      .NREQ (NREQ),
      .CW   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .prescaler (prescaler),
      .req       (req),
      .load      (load),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .cur_id    (cur_id),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_gnt"},    int'(gnt),    0);
      check({tag, "_done"},   int'(done),   0);
      check({tag, "_busy"},   int'(busy),   0);
      check({tag, "_cur_id"}, int'(cur_id), 0);
      check({tag, "_count"},  int'(count),  0);
   endtask

   task automatic expect_ev(input bit d, input int id, input int c);
      ev_t e;
      e.is_done = d;
      e.id      = id;
      e.cyc     = c;
      exp_q.push_back(e);
   endtask

   task automatic set_load(input int i, input int v);
      load[i*CW +: CW] = CW'(v);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset(tag);
   endtask

   // Compare one observed grant or done event against the head of the queue.
   task automatic handle(input bit d, input logic [NREQ-1:0] v);
      int   id;
      ev_t  e;
      id = -1;
      if ($countones(v) == 1) begin
         for (int i = 0; i < NREQ; i++) begin
            if (v[i]) id = i;
         end
      end
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_%s: id %0d at cycle %0d, none expected",
                  d ? "done" : "gnt", id, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.is_done != d || e.id != id || e.cyc != cyc) begin
            fails++;
            $display("FAIL event: got %s id %0d cycle %0d, expected %s id %0d cycle %0d",
                     d ? "done" : "gnt", id, cyc, e.is_done ? "done" : "gnt", e.id, e.cyc);
         end
      end
   endtask

   // Monitor: sample away from the rising edge, report grant rises and done pulses.
   initial begin : monitor
      logic [NREQ-1:0] prev_gnt;
      prev_gnt = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_gnt = '0;
         end else begin
            if (done !== '0) handle(1'b1, done);
            if (gnt !== '0 && prev_gnt === '0) handle(1'b0, gnt);
            prev_gnt = gnt;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int k;
      rst       = 1'b1;
      en        = 1'b0;
      req       = '0;
      prescaler = '0;
      load      = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset("por");

      // Single request: load 3, prescaler 1 -> 6 RUN cycles after the LOAD cycle.
      en = 1'b1;
      prescaler = CW'(1);
      set_load(0, 3);
      k = cyc;
      req = 4'b0001;
      expect_ev(1'b0, 0, k + 1);
      expect_ev(1'b1, 0, k + 8);
      wait_until(k + 1); check("t1_gnt", int'(gnt), 1);
      wait_until(k + 2); check("t1_cnt3", int'(count), 3);
      wait_until(k + 4); check("t1_cnt2", int'(count), 2);
      wait_until(k + 6); check("t1_cnt1", int'(count), 1);
      wait_until(k + 8);
      check("t1_cnt0", int'(count), 0);
      check("t1_busy_done", int'(busy), 1);
      check("t1_cur_id", int'(cur_id), 0);
      req = '0;
      wait_until(k + 9); check("t1_busy_idle", int'(busy), 0);
      wait_until(k + 12);

      // Contention from reset: loads 1, prescaler 0 -> order 0,1,2,3,0 every 4 cycles.
      do_reset("t2rst");
      prescaler = '0;
      for (int i = 0; i < NREQ; i++) set_load(i, 1);
      k = cyc;
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         expect_ev(1'b0, j % NREQ, k + 1 + 4 * j);
         expect_ev(1'b1, j % NREQ, k + 3 + 4 * j);
      end
      wait_until(k + 19);
      req = '0;
      wait_until(k + 22);

      // Zero load: LOAD then straight to DONE.
      set_load(2, 0);
      k = cyc;
      req = 4'b0100;
      expect_ev(1'b0, 2, k + 1);
      expect_ev(1'b1, 2, k + 2);
      wait_until(k + 2);
      check("t3_count", int'(count), 0);
      check("t3_busy", int'(busy), 1);
      req = '0;
      wait_until(k + 5);

      // Abort after two RUN cycles; owner load edits after LOAD are ignored.
      set_load(1, 10);
      set_load(2, 2);
      k = cyc;
      req = 4'b0010;
      expect_ev(1'b0, 1, k + 1);
      wait_until(k + 3);
      set_load(1, 3);
      wait_until(k + 4);
      check("t4_cnt_run", int'(count), 8);
      req = 4'b0101;
      wait_until(k + 5);
      check("t4_gnt_clear", int'(gnt), 0);
      check("t4_cnt_hold", int'(count), 8);
      check("t4_busy", int'(busy), 0);
      check("t4_cur_id", int'(cur_id), 1);
      expect_ev(1'b0, 2, k + 6);
      expect_ev(1'b1, 2, k + 9);
      wait_until(k + 9);
      req = '0;
      wait_until(k + 12);

      // en low for 5 cycles mid-RUN delays expiry by exactly 5 cycles.
      set_load(0, 4);
      k = cyc;
      req = 4'b0001;
      expect_ev(1'b0, 0, k + 1);
      expect_ev(1'b1, 0, k + 11);
      wait_until(k + 3);
      check("t5_cnt_pre", int'(count), 3);
      en = 1'b0;
      wait_until(k + 6);
      check("t5_gnt_stall", int'(gnt), 1);
      check("t5_cnt_stall", int'(count), 3);
      wait_until(k + 8);
      check("t5_cnt_end", int'(count), 3);
      en = 1'b1;
      wait_until(k + 11);
      req = '0;
      wait_until(k + 14);

      // Prescaler 7 -> 2 while ps_cnt=4: decrement on the next cycle.
      set_load(3, 2);
      prescaler = CW'(7);
      k = cyc;
      req = 4'b1000;
      expect_ev(1'b0, 3, k + 1);
      expect_ev(1'b1, 3, k + 10);
      wait_until(k + 6);
      check("t5b_cnt_before", int'(count), 2);
      prescaler = CW'(2);
      wait_until(k + 7);
      check("t5b_cnt_after", int'(count), 1);
      wait_until(k + 10);
      req = '0;
      prescaler = '0;
      wait_until(k + 13);

      // Reset mid-RUN at count 5, then req=1001 goes to requester 0 first.
      set_load(1, 8);
      k = cyc;
      req = 4'b0010;
      expect_ev(1'b0, 1, k + 1);
      wait_until(k + 5);
      check("t6_cnt5", int'(count), 5);
      rst = 1'b1;
      req = 4'b1001;
      set_load(0, 1);
      wait_until(k + 6);
      rst = 1'b0;
      check_reset("t6rst");
      expect_ev(1'b0, 0, k + 7);
      expect_ev(1'b1, 0, k + 9);
      wait_until(k + 9);
      req = '0;
      wait_until(k + 14);

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
